// File: rtl/clock_comp_tx_param_if.sv
// Block stream between the encoder side and the scrambler side of the
// TX clock-compensation stage.
interface clock_comp_tx_param_if #(
    parameter int NB_DATA = 66
);
    logic               i_valid;
    logic [NB_DATA-1:0] i_data;
    logic [NB_DATA-1:0] o_data;
    logic               o_valid;
    logic               o_aligner_tag;

    modport master (
        output i_valid, i_data,
        input  o_data, o_valid, o_aligner_tag
    );

    modport slave (
        input  i_valid, i_data,
        output o_data, o_valid, o_aligner_tag
    );
endinterface

// File: rtl/clock_comp_tx_param.sv
// TX clock compensation: opens N_LANES tagged idle slots per period for
// alignment-marker insertion and pays them back by deleting incoming idles.
// Owed deletions are carried across periods in a saturating deficit counter.
module clock_comp_tx_param #(
    parameter int NB_DATA         = 66,
    parameter int N_LANES         = 20,
    parameter int AM_BLOCK_PERIOD = 16383,
    parameter int NB_ADDR         = 5,
    parameter int PRELOAD         = 2
) (
    input  logic                             i_clock,
    input  logic                             i_reset,
    input  logic                             i_enable,
    input  logic                             i_bypass,
    clock_comp_tx_param_if.slave             bus,
    output logic [NB_ADDR:0]                 o_fifo_level,
    output logic [$clog2(4*N_LANES+1)-1:0]   o_deficit,
    output logic                             o_overflow,
    output logic                             o_underflow
);
    localparam int P      = AM_BLOCK_PERIOD * N_LANES;
    localparam int NB_PC  = (P > 1) ? $clog2(P) : 1;
    localparam int NB_DEF = $clog2(4*N_LANES+1);
    localparam int DEPTH  = 2**NB_ADDR;

    localparam logic [NB_DATA-1:0] PCS_IDLE   = NB_DATA'(66'h2_e000_0000_0000_0000);
    localparam logic [NB_PC-1:0]   PC_LAST    = NB_PC'(P - 1);
    localparam logic [NB_PC-1:0]   PC_GAP_END = NB_PC'(N_LANES);
    localparam logic [NB_DEF-1:0]  DEF_MAX    = NB_DEF'(4 * N_LANES);
    localparam logic [NB_ADDR:0]   LEVEL_FULL = (NB_ADDR+1)'(DEPTH);
    localparam logic [NB_ADDR:0]   LEVEL_INIT = (NB_ADDR+1)'(PRELOAD);
    localparam logic [NB_ADDR-1:0] WPTR_INIT  = NB_ADDR'(PRELOAD);

    logic [NB_DATA-1:0] mem [0:DEPTH-1];
    logic [NB_ADDR-1:0] wr_ptr;
    logic [NB_ADDR-1:0] rd_ptr;
    logic [NB_ADDR:0]   level;
    logic [NB_ADDR:0]   level_nxt;
    logic [NB_PC-1:0]   pc;
    logic [NB_DEF-1:0]  deficit;
    logic [NB_DEF-1:0]  deficit_nxt;

    logic active, gap, is_idle, drop;
    logic wr_req, rd_req, fifo_full, fifo_empty, wr_ok, rd_ok;

    // Per-cycle decisions: gap slot, idle deletion and FIFO access qualification.
    always_comb begin
        active     = i_enable & bus.i_valid & ~i_bypass;
        gap        = (pc < PC_GAP_END);
        is_idle    = (bus.i_data == PCS_IDLE);
        drop       = is_idle & ((deficit != '0) | gap);
        wr_req     = active & ~drop;
        rd_req     = active & ~gap;
        fifo_full  = (level == LEVEL_FULL);
        fifo_empty = (level == '0);
        // A full FIFO can still accept a write when the head leaves the same cycle.
        wr_ok      = wr_req & (~fifo_full | rd_req);
        // An empty FIFO cannot supply a read, but a same-cycle write still lands.
        rd_ok      = rd_req & ~fifo_empty;

        level_nxt = level;
        case ({wr_ok, rd_ok})
            2'b10:   level_nxt = level + 1'b1;
            2'b01:   level_nxt = level - 1'b1;
            default: level_nxt = level;
        endcase

        // Gap and drop together cancel; a gap on a saturated deficit is lost.
        deficit_nxt = deficit;
        if (gap && !drop) begin
            if (deficit != DEF_MAX)
                deficit_nxt = deficit + 1'b1;
        end else if (!gap && drop) begin
            deficit_nxt = deficit - 1'b1;
        end
    end

    // Period counter, deficit, FIFO pointers/level and sticky error flags.
    always_ff @(posedge i_clock) begin
        if (i_reset) begin
            pc          <= '0;
            deficit     <= '0;
            wr_ptr      <= WPTR_INIT;
            rd_ptr      <= '0;
            level       <= LEVEL_INIT;
            o_overflow  <= 1'b0;
            o_underflow <= 1'b0;
        end else if (i_enable) begin
            if (i_bypass) begin
                // Held in post-reset state so leaving bypass restarts cleanly.
                pc      <= '0;
                deficit <= '0;
                wr_ptr  <= WPTR_INIT;
                rd_ptr  <= '0;
                level   <= LEVEL_INIT;
            end else if (active) begin
                pc      <= (pc == PC_LAST) ? '0 : pc + 1'b1;
                deficit <= deficit_nxt;
                level   <= level_nxt;
                if (wr_ok)
                    wr_ptr <= wr_ptr + 1'b1;
                if (rd_ok)
                    rd_ptr <= rd_ptr + 1'b1;
                if (wr_req && fifo_full && !rd_req)
                    o_overflow <= 1'b1;
                if (rd_req && fifo_empty)
                    o_underflow <= 1'b1;
            end
        end
    end

    // FIFO storage; the first PRELOAD slots are refilled with idles on restart.
    always_ff @(posedge i_clock) begin
        if (i_reset || (i_enable && i_bypass)) begin
            for (int i = 0; i < PRELOAD; i++)
                mem[NB_ADDR'(i)] <= PCS_IDLE;
        end else if (wr_ok) begin
            mem[wr_ptr] <= bus.i_data;
        end
    end

    // Registered output: gap slot, FIFO head, underflow idle or bypass data.
    always_ff @(posedge i_clock) begin
        if (i_reset) begin
            bus.o_data        <= PCS_IDLE;
            bus.o_valid       <= 1'b0;
            bus.o_aligner_tag <= 1'b0;
        end else if (!i_enable || !bus.i_valid) begin
            bus.o_valid <= 1'b0;
        end else begin
            bus.o_valid <= 1'b1;
            if (i_bypass) begin
                bus.o_data        <= bus.i_data;
                bus.o_aligner_tag <= 1'b0;
            end else if (gap) begin
                bus.o_data        <= PCS_IDLE;
                bus.o_aligner_tag <= 1'b1;
            end else begin
                bus.o_data        <= rd_ok ? mem[rd_ptr] : PCS_IDLE;
                bus.o_aligner_tag <= 1'b0;
            end
        end
    end

    assign o_fifo_level = level;
    assign o_deficit    = deficit;
endmodule

// File: tb/tb_clock_comp_tx_param.sv
// Directed bench for clock_comp_tx_param with a short period (P=32, D=16).
module tb_clock_comp_tx_param;
    localparam int NB_DATA = 66;
    localparam logic [65:0] IDLE = 66'h2_e000_0000_0000_0000;

    logic       i_clock = 1'b0;
    logic       i_reset;
    logic       i_enable;
    logic       i_bypass;
    logic [4:0] o_fifo_level;
    logic [4:0] o_deficit;
    logic       o_overflow;
    logic       o_underflow;

    int n_cmp = 0;
    int n_err = 0;

    logic [65:0] q[$];
    logic [65:0] exp_d;
    logic [65:0] din;
    int          seq;

    clock_comp_tx_param_if #(.NB_DATA(NB_DATA)) bus ();

    clock_comp_tx_param #(
        .NB_DATA(NB_DATA), .N_LANES(4), .AM_BLOCK_PERIOD(8), .NB_ADDR(4), .PRELOAD(2)
    ) dut (
        .i_clock(i_clock), .i_reset(i_reset), .i_enable(i_enable), .i_bypass(i_bypass),
        .bus(bus.master),
        .o_fifo_level(o_fifo_level), .o_deficit(o_deficit),
        .o_overflow(o_overflow), .o_underflow(o_underflow)
    );

    always #5 i_clock = ~i_clock;

    function automatic logic [65:0] dat(input int n);
        return {2'b01, 32'hD0D0_0000, 32'(n)};
    endfunction

    task automatic chk(input string tag, input logic [65:0] obs, input logic [65:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic step(input logic v, input logic [65:0] d);
        bus.i_valid = v;
        bus.i_data  = d;
        @(posedge i_clock);
        #1;
    endtask

    task automatic do_reset();
        i_reset     = 1'b1;
        i_enable    = 1'b1;
        i_bypass    = 1'b0;
        bus.i_valid = 1'b0;
        bus.i_data  = '0;
        repeat (2) @(posedge i_clock);
        #1;
        i_reset = 1'b0;
    endtask

    task automatic chk_reset_state(input string tag);
        chk({tag, "_data"},  bus.o_data, IDLE);
        chk({tag, "_valid"}, 66'(bus.o_valid), 66'd0);
        chk({tag, "_tag"},   66'(bus.o_aligner_tag), 66'd0);
        chk({tag, "_level"}, 66'(o_fifo_level), 66'd2);
        chk({tag, "_def"},   66'(o_deficit), 66'd0);
        chk({tag, "_ovf"},   66'(o_overflow), 66'd0);
        chk({tag, "_unf"},   66'(o_underflow), 66'd0);
    endtask

    initial begin
        // Reset state
        do_reset();
        chk_reset_state("rst");

        // No idles: gaps fill the FIFO until it overflows on the 3rd slot of gap 4
        for (int k = 0; k < 132; k++) begin
            step(1'b1, dat(k));
            if (k < 4) begin
                chk("noidle_gap_tag", 66'(bus.o_aligner_tag), 66'd1);
                chk("noidle_gap_data", bus.o_data, IDLE);
            end
            if (k == 3) begin
                chk("noidle_lvl_g1", 66'(o_fifo_level), 66'd6);
                chk("noidle_def_g1", 66'(o_deficit), 66'd4);
            end
            if (k == 4 || k == 5) begin
                chk("noidle_pre_data", bus.o_data, IDLE);
                chk("noidle_pre_tag", 66'(bus.o_aligner_tag), 66'd0);
            end
            if (k == 6)  chk("noidle_d0", bus.o_data, dat(0));
            if (k == 7)  chk("noidle_d1", bus.o_data, dat(1));
            if (k == 36) chk("noidle_d26", bus.o_data, dat(26));
            if (k == 35) chk("noidle_lvl_g2", 66'(o_fifo_level), 66'd10);
            if (k == 67) chk("noidle_lvl_g3", 66'(o_fifo_level), 66'd14);
            if (k == 97) begin
                chk("noidle_lvl_full", 66'(o_fifo_level), 66'd16);
                chk("noidle_ovf_pre", 66'(o_overflow), 66'd0);
            end
            if (k == 98) begin
                chk("noidle_ovf", 66'(o_overflow), 66'd1);
                chk("noidle_lvl_hold", 66'(o_fifo_level), 66'd16);
            end
            if (k == 99)  chk("noidle_def16", 66'(o_deficit), 66'd16);
            if (k == 131) begin
                chk("noidle_def_sat", 66'(o_deficit), 66'd16);
                chk("noidle_ovf_sticky", 66'(o_overflow), 66'd1);
            end
        end

        // Steady compensation: 4 idles right after each gap, 20 periods
        do_reset();
        q = {IDLE, IDLE};
        seq = 0;
        for (int p = 0; p < 20; p++) begin
            for (int s = 0; s < 32; s++) begin
                if (s >= 4 && s < 8) din = IDLE;
                else begin
                    din = dat(seq);
                    seq++;
                end
                step(1'b1, din);
                if (s < 4) begin
                    chk("steady_gap_tag", 66'(bus.o_aligner_tag), 66'd1);
                    chk("steady_gap_data", bus.o_data, IDLE);
                end else begin
                    exp_d = (q.size() > 0) ? q.pop_front() : IDLE;
                    chk("steady_data", bus.o_data, exp_d);
                    chk("steady_tag", 66'(bus.o_aligner_tag), 66'd0);
                end
                if (din != IDLE) q.push_back(din);
                if (s == 3)  chk("steady_def_peak", 66'(o_deficit), 66'd4);
                if (s == 31) begin
                    chk("steady_level", 66'(o_fifo_level), 66'd2);
                    chk("steady_def", 66'(o_deficit), 66'd0);
                end
            end
        end
        chk("steady_ovf", 66'(o_overflow), 66'd0);
        chk("steady_unf", 66'(o_underflow), 66'd0);

        // Deficit carry: no idles in period 1, eight idles after gap of period 2
        do_reset();
        for (int k = 0; k < 32; k++) step(1'b1, dat(k));
        chk("carry_def_p1", 66'(o_deficit), 66'd4);
        chk("carry_lvl_p1", 66'(o_fifo_level), 66'd6);
        for (int k = 0; k < 4; k++) step(1'b1, dat(32 + k));
        chk("carry_def_peak", 66'(o_deficit), 66'd8);
        chk("carry_lvl_peak", 66'(o_fifo_level), 66'd10);
        for (int k = 0; k < 8; k++) begin
            step(1'b1, IDLE);
            if (k == 3) chk("carry_def_mid", 66'(o_deficit), 66'd4);
        end
        chk("carry_def_zero", 66'(o_deficit), 66'd0);
        chk("carry_lvl_back", 66'(o_fifo_level), 66'd2);
        for (int k = 0; k < 20; k++) step(1'b1, dat(40 + k));
        chk("carry_lvl_end", 66'(o_fifo_level), 66'd2);
        chk("carry_ovf", 66'(o_overflow), 66'd0);
        chk("carry_unf", 66'(o_underflow), 66'd0);

        // Idle arriving on the first gap slot with zero deficit
        do_reset();
        step(1'b1, IDLE);
        chk("gapidle_def", 66'(o_deficit), 66'd0);
        chk("gapidle_lvl", 66'(o_fifo_level), 66'd2);
        chk("gapidle_tag", 66'(bus.o_aligner_tag), 66'd1);
        chk("gapidle_valid", 66'(bus.o_valid), 66'd1);

        // Bypass mid-period, then restart as after reset
        do_reset();
        for (int k = 0; k < 10; k++) step(1'b1, dat(k));
        i_bypass = 1'b1;
        for (int k = 0; k < 10; k++) begin
            step(1'b1, dat(100 + k));
            chk("byp_data", bus.o_data, dat(100 + k));
            chk("byp_tag", 66'(bus.o_aligner_tag), 66'd0);
            chk("byp_valid", 66'(bus.o_valid), 66'd1);
        end
        chk("byp_lvl", 66'(o_fifo_level), 66'd2);
        chk("byp_def", 66'(o_deficit), 66'd0);
        i_bypass = 1'b0;
        for (int k = 0; k < 4; k++) begin
            step(1'b1, IDLE);
            chk("byp_exit_tag", 66'(bus.o_aligner_tag), 66'd1);
            chk("byp_exit_lvl", 66'(o_fifo_level), 66'd2);
        end
        step(1'b1, dat(200));
        chk("byp_after_pre0", bus.o_data, IDLE);
        chk("byp_after_tag", 66'(bus.o_aligner_tag), 66'd0);
        step(1'b1, dat(201));
        chk("byp_after_pre1", bus.o_data, IDLE);
        step(1'b1, dat(202));
        chk("byp_after_d200", bus.o_data, dat(200));

        // Freeze for 5 cycles mid-period, then verify pc resumes unchanged
        do_reset();
        for (int k = 0; k < 10; k++) step(1'b1, dat(k));
        chk("frz_pre_data", bus.o_data, dat(3));
        i_enable = 1'b0;
        for (int k = 0; k < 5; k++) begin
            step(1'b1, dat(50 + k));
            chk("frz_valid", 66'(bus.o_valid), 66'd0);
            chk("frz_data", bus.o_data, dat(3));
            chk("frz_lvl", 66'(o_fifo_level), 66'd6);
            chk("frz_def", 66'(o_deficit), 66'd4);
        end
        i_enable = 1'b1;
        for (int k = 0; k < 23; k++) begin
            step(1'b1, dat(10 + k));
            if (k == 0) chk("frz_resume_d4", bus.o_data, dat(4));
            chk("frz_pc_tag", 66'(bus.o_aligner_tag), (k < 22) ? 66'd0 : 66'd1);
        end
        for (int k = 0; k < 80; k++) step(1'b1, dat(40 + k));
        chk("frz_ovf_set", 66'(o_overflow), 66'd1);
        i_reset = 1'b1;
        step(1'b1, dat(999));
        i_reset = 1'b0;
        chk_reset_state("midrst");
        step(1'b1, dat(1000));
        chk("midrst_first_gap", 66'(bus.o_aligner_tag), 66'd1);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end
endmodule
